mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Arbitrates the shared main-memory port between the two pipeline cores of the dual-core processor.
- Handles line-fill reads and copy-back writes.
- On a read, snoops the other core's cache first. If that cache holds the line dirty, its data is forwarded to the requester and copied back to memory.
- Sits between both cores' memory stages and the main memory model. It replaces the direct per-core mem_rd/main_mem_wr drive.

Parameters:
- MEM_LAT, 4, main-memory access latency in cycles (>=1); mem_rd/mem_wr held this many cycles.
- ADDR_W, 5, memory address width.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_1, req_2  in  1  core request; held high until done_x seen.
- wr_1, wr_2  in  1  1 = copy-back write, 0 = line-fill read.
- addr_1, addr_2  in  ADDR_W  request address.
- wdata_1, wdata_2  in  DATA_W  write data (valid when wr_x=1).
- gnt_1, gnt_2  out  1  core owns the bus; high for the whole transaction.
- done_1, done_2  out  1  one-cycle completion pulse.
- rdata  out  DATA_W  read result; valid while done_x=1.
- snoop_req_1, snoop_req_2  out  1  snoop probe to the non-granted core.
- snoop_addr  out  ADDR_W  probed address.
- snoop_dirty_1, snoop_dirty_2  in  1  probed core holds the line modified (combinational response).
- snoop_data_1, snoop_data_2  in  DATA_W  dirty line data from the probed core.
- mem_rd, mem_wr  out  1  main-memory strobes.
- mem_addr  out  ADDR_W  main-memory address.
- mem_wdata  out  DATA_W  main-memory write data.
- mem_rdata  in  DATA_W  main-memory read data; valid on the last cycle of mem_rd.

Behaviour:
- States: IDLE, SNOOP, MEM, WB, RESP.
- Registered context: owner (1/2), op (rd/wr), addr, data, last_gnt, latency counter.
- Reset (async, reset=0):
  - state=IDLE, last_gnt=2 (core 1 wins the first tie), counter=0.
  - All outputs 0: gnt, done, snoop_req, mem_rd, mem_wr, rdata, mem_addr, mem_wdata, snoop_addr.
- Reset asserted mid-transaction: abort immediately, no done issued, no further memory strobes. The requester reissues.
- IDLE:
  - Only one req high: grant that core.
  - Both high: grant the core != last_gnt.
  - On grant: latch wr/addr/wdata, set gnt_owner.
  - Next state: SNOOP if read, MEM if write (counter=MEM_LAT-1).
- SNOOP (exactly 1 cycle):
  - snoop_req of the other core=1, snoop_addr=latched addr.
  - snoop_dirty sampled at the cycle end.
  - Dirty: data<=snoop_data, next WB.
  - Clean: next MEM (read).
- MEM:
  - mem_rd (read) or mem_wr (write) held high; mem_addr=addr; mem_wdata=data for writes.
  - Counter decrements each cycle. At counter=0, a read captures mem_rdata into data. Next RESP.
- WB: mem_wr=1, mem_wdata=snoop data, MEM_LAT cycles. Next RESP.
- RESP:
  - done_owner=1, rdata=data (writes return the written word), gnt still high.
  - last_gnt<=owner. Next IDLE with gnt dropped.
- Requester rule: req is low in the cycle after done. A req dropped before done is ignored; the transaction completes.
- Latency from the IDLE sampling cycle to the done cycle:
  - Write: MEM_LAT+1.
  - Read, clean or dirty: MEM_LAT+2.
- Invariants:
  - gnt_1 and gnt_2 are never both high.
  - mem_rd and mem_wr are never both high.
  - A snoop never targets the granted core.
- Starvation: a losing requester is served next; worst-case wait is one transaction.

Test Plan:
- Write: req_1=1, wr_1=1, addr=5'h0A, wdata=32'hDEADBEEF, MEM_LAT=4 -> mem_wr high 4 cycles with mem_addr=0A and mem_wdata=DEADBEEF; done_1 5 cycles after request; no snoop_req.
- Clean read: core 2 reads 5'h03, snoop_dirty_1=0, memory returns 32'h12345678 -> snoop_req_1 for 1 cycle, mem_rd 4 cycles, done_2 with rdata=12345678 at MEM_LAT+2.
- Dirty read: core 1 reads 5'h07, snoop_dirty_2=1 with snoop_data_2=32'hCAFEF00D -> mem_rd never asserted; mem_wr 4 cycles writing CAFEF00D to 07; done_1 with rdata=CAFEF00D.
- Tie and round-robin: both cores request writes continuously from reset -> grants alternate 1,2,1,2; gnt never overlaps.
- Reset mid-op: drop reset during MEM of a read -> all outputs 0 in the same cycle, no done; after release with req_1 still high, the transaction restarts from IDLE.
- MEM_LAT=1: read -> mem_rd high exactly 1 cycle, done at cycle 3.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares the single main-memory port between the two pipeline cores.
//   A core may issue a line-fill read or a copy-back write. Before a read
//   reaches memory, the other core's cache is snooped. If that cache holds the
//   line dirty, its data is forwarded to the requester and copied back to
//   memory in place of the memory read.
//
// Ports
//   clk, reset                      clock (rising edge), async active-low reset
//   req_x / wr_x / addr_x / wdata_x core request, held until done_x is seen
//   gnt_x                           core owns the bus for the whole transaction
//   done_x, rdata                   one-cycle completion pulse and result word
//   snoop_req_x, snoop_addr         probe to the non-granted core
//   snoop_dirty_x, snoop_data_x     combinational probe response
//   mem_rd, mem_wr, mem_addr,       main-memory strobes, address and write
//   mem_wdata, mem_rdata            data (held MEM_LAT cycles); read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_1,
  input  logic              req_2,
  input  logic              wr_1,
  input  logic              wr_2,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [ADDR_W-1:0] addr_2,
  input  logic [DATA_W-1:0] wdata_1,
  input  logic [DATA_W-1:0] wdata_2,
  output logic              gnt_1,
  output logic              gnt_2,
  output logic              done_1,
  output logic              done_2,
  output logic [DATA_W-1:0] rdata,
  output logic              snoop_req_1,
  output logic              snoop_req_2,
  output logic [ADDR_W-1:0] snoop_addr,
  input  logic              snoop_dirty_1,
  input  logic              snoop_dirty_2,
  input  logic [DATA_W-1:0] snoop_data_1,
  input  logic [DATA_W-1:0] snoop_data_2,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {IDLE, SNOOP, MEM, WB, RESP} state_t;

  state_t              state_q;
  logic                owner2_q;   // 1: core 2 owns the bus, 0: core 1
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                last2_q;    // 1: core 2 was granted last
  logic [CNT_W-1:0]    cnt_q;

  logic                gnt_1_q, gnt_2_q, done_1_q, done_2_q;
  logic                snoop_req_1_q, snoop_req_2_q, mem_rd_q, mem_wr_q;
  logic [DATA_W-1:0]   rdata_q, mem_wdata_q;
  logic [ADDR_W-1:0]   snoop_addr_q, mem_addr_q;

  // Arbitration and selection of the winning core's request fields.
  logic                sel_2_d;
  logic                sel_wr_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic [DATA_W-1:0]   sel_wdata_d;
  logic                snp_dirty_d;
  logic [DATA_W-1:0]   snp_data_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel_2_d     = 1'b0;
    // A tie goes to the core that was not granted last.
    if (req_2 && (!req_1 || !last2_q)) sel_2_d = 1'b1;
    sel_wr_d    = sel_2_d ? wr_2    : wr_1;
    sel_addr_d  = sel_2_d ? addr_2  : addr_1;
    sel_wdata_d = sel_2_d ? wdata_2 : wdata_1;
    // The probe always targets the core that does not own the bus.
    snp_dirty_d = owner2_q ? snoop_dirty_1 : snoop_dirty_2;
    snp_data_d  = owner2_q ? snoop_data_1  : snoop_data_2;
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // in this block sees the values from the start of the cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      owner2_q      <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      last2_q       <= 1'b1;
      cnt_q         <= '0;
      gnt_1_q       <= 1'b0;
      gnt_2_q       <= 1'b0;
      done_1_q      <= 1'b0;
      done_2_q      <= 1'b0;
      rdata_q       <= '0;
      snoop_req_1_q <= 1'b0;
      snoop_req_2_q <= 1'b0;
      snoop_addr_q  <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
    end else begin
      done_1_q <= 1'b0;
      done_2_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_1 || req_2) begin
            owner2_q <= sel_2_d;
            wr_q     <= sel_wr_d;
            addr_q   <= sel_addr_d;
            data_q   <= sel_wdata_d;
            gnt_1_q  <= !sel_2_d;
            gnt_2_q  <= sel_2_d;
            if (sel_wr_d) begin
              state_q     <= MEM;
              cnt_q       <= LAT_M1;
              mem_wr_q    <= 1'b1;
              mem_addr_q  <= sel_addr_d;
              mem_wdata_q <= sel_wdata_d;
            end else begin
              state_q       <= SNOOP;
              snoop_req_1_q <= sel_2_d;
              snoop_req_2_q <= !sel_2_d;
              snoop_addr_q  <= sel_addr_d;
            end
          end
        end
        SNOOP: begin
          snoop_req_1_q <= 1'b0;
          snoop_req_2_q <= 1'b0;
          snoop_addr_q  <= '0;
          cnt_q         <= LAT_M1;
          mem_addr_q    <= addr_q;
          if (snp_dirty_d) begin
            // Dirty line: forward the peer's copy and write it back instead of reading.
            state_q     <= WB;
            data_q      <= snp_data_d;
            mem_wr_q    <= 1'b1;
            mem_wdata_q <= snp_data_d;
          end else begin
            state_q  <= MEM;
            mem_rd_q <= 1'b1;
          end
        end
        MEM, WB: begin
          if (cnt_q == '0) begin
            state_q     <= RESP;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            done_1_q    <= !owner2_q;
            done_2_q    <= owner2_q;
            // Memory read data is only valid on the last strobe cycle.
            if (state_q == MEM && !wr_q) begin
              data_q  <= mem_rdata;
              rdata_q <= mem_rdata;
            end else begin
              rdata_q <= data_q;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          gnt_1_q <= 1'b0;
          gnt_2_q <= 1'b0;
          last2_q <= owner2_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_1       = gnt_1_q;
  assign gnt_2       = gnt_2_q;
  assign done_1      = done_1_q;
  assign done_2      = done_2_q;
  assign rdata       = rdata_q;
  assign snoop_req_1 = snoop_req_1_q;
  assign snoop_req_2 = snoop_req_2_q;
  assign snoop_addr  = snoop_addr_q;
  assign mem_rd      = mem_rd_q;
  assign mem_wr      = mem_wr_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Bench for mem_bus_arbiter. A transaction-level model predicts, for every
//   cycle, which core owns the bus and which strobes must be active, given the
//   cycle offset from the accepting IDLE cycle. Directed scenarios add literal
//   expectations for latency, strobe counts, grant order and returned data.
//   A second instance runs with MEM_LAT=1.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_1, req_2, wr_1, wr_2;
  logic [4:0]  addr_1, addr_2;
  logic [31:0] wdata_1, wdata_2;
  logic        gnt_1, gnt_2, done_1, done_2;
  logic [31:0] rdata;
  logic        snoop_req_1, snoop_req_2;
  logic [4:0]  snoop_addr;
  logic        snoop_dirty_1, snoop_dirty_2;
  logic [31:0] snoop_data_1, snoop_data_2;
  logic        mem_rd, mem_wr;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  // Peer-cache configuration that the snoop responder presents.
  bit          dirty_cfg_1 = 1'b0, dirty_cfg_2 = 1'b0;
  logic [31:0] sdata_cfg_1 = 32'h0, sdata_cfg_2 = 32'h0;

  // Second instance with MEM_LAT=1: core 1 only.
  logic        b_req_1;
  logic        b_gnt_1, b_gnt_2, b_done_1, b_done_2;
  logic [31:0] b_rdata;
  logic        b_snoop_req_1, b_snoop_req_2;
  logic [4:0]  b_snoop_addr;
  logic        b_mem_rd, b_mem_wr;
  logic [4:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [4:0] a);
    if (a == 5'h03) return 32'h12345678;
    return {3'b000, a, 24'hC0FFEE};
  endfunction

  // Main memory: data is presented only on the last cycle of a read strobe.
  int rd_run = 0, b_rd_run = 0;
  always @(posedge clk) begin
    rd_run   <= mem_rd   ? rd_run + 1   : 0;
    b_rd_run <= b_mem_rd ? b_rd_run + 1 : 0;
  end
  assign mem_rdata   = (mem_rd && rd_run == L - 1) ? mem_word(mem_addr)   : 32'hA5A5A5A5;
  assign b_mem_rdata = (b_mem_rd && b_rd_run == 0) ? mem_word(b_mem_addr) : 32'hA5A5A5A5;

  assign snoop_dirty_1 = snoop_req_1 & dirty_cfg_1;
  assign snoop_dirty_2 = snoop_req_2 & dirty_cfg_2;
  assign snoop_data_1  = sdata_cfg_1;
  assign snoop_data_2  = sdata_cfg_2;

  mem_bus_arbiter #(.MEM_LAT(L), .ADDR_W(5), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .req_1(req_1), .req_2(req_2), .wr_1(wr_1), .wr_2(wr_2),
    .addr_1(addr_1), .addr_2(addr_2), .wdata_1(wdata_1), .wdata_2(wdata_2),
    .gnt_1(gnt_1), .gnt_2(gnt_2), .done_1(done_1), .done_2(done_2), .rdata(rdata),
    .snoop_req_1(snoop_req_1), .snoop_req_2(snoop_req_2), .snoop_addr(snoop_addr),
    .snoop_dirty_1(snoop_dirty_1), .snoop_dirty_2(snoop_dirty_2),
    .snoop_data_1(snoop_data_1), .snoop_data_2(snoop_data_2),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.MEM_LAT(1), .ADDR_W(5), .DATA_W(32)) u_dut_lat1 (
    .clk(clk), .reset(reset),
    .req_1(b_req_1), .req_2(1'b0), .wr_1(1'b0), .wr_2(1'b0),
    .addr_1(5'h03), .addr_2(5'h00), .wdata_1(32'h0), .wdata_2(32'h0),
    .gnt_1(b_gnt_1), .gnt_2(b_gnt_2), .done_1(b_done_1), .done_2(b_done_2), .rdata(b_rdata),
    .snoop_req_1(b_snoop_req_1), .snoop_req_2(b_snoop_req_2), .snoop_addr(b_snoop_addr),
    .snoop_dirty_1(1'b0), .snoop_dirty_2(1'b0),
    .snoop_data_1(32'h0), .snoop_data_2(32'h0),
    .mem_rd(b_mem_rd), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Strobe counters and grant-order log.
  int n_mem_wr = 0, n_mem_rd = 0, n_snp1 = 0, n_snp2 = 0, b_n_mem_rd = 0;
  int glog[$];
  logic prev_g1 = 1'b0, prev_g2 = 1'b0;
  always @(negedge clk) begin
    if (mem_wr)      n_mem_wr   <= n_mem_wr + 1;
    if (mem_rd)      n_mem_rd   <= n_mem_rd + 1;
    if (snoop_req_1) n_snp1     <= n_snp1 + 1;
    if (snoop_req_2) n_snp2     <= n_snp2 + 1;
    if (b_mem_rd)    b_n_mem_rd <= b_n_mem_rd + 1;
    if (gnt_1 && !prev_g1) glog.push_back(1);
    if (gnt_2 && !prev_g2) glog.push_back(2);
    prev_g1 <= gnt_1;
    prev_g2 <= gnt_2;
  end

  // ---------------- transaction-level model ----------------
  typedef struct {
    bit          active;
    int          owner;
    bit          wr;
    logic [4:0]  addr;
    logic [31:0] data;
    int          t0;
    bit          dirty;
  } txn_t;

  txn_t m;
  int   m_last;
  int   cyc;

  function automatic int done_k(input bit w);
    return w ? L + 1 : L + 2;
  endfunction

  initial begin
    m = '{default: 0};
    m_last = 2;
    cyc = 0;
    forever begin
      @(posedge clk);
      if (!reset) begin
        m.active = 1'b0;
        m_last   = 2;
      end else if (m.active) begin
        if (!m.wr && cyc == m.t0 + 1) m.dirty = (m.owner == 1) ? dirty_cfg_2 : dirty_cfg_1;
        if (cyc == m.t0 + done_k(m.wr)) begin
          m.active = 1'b0;
          m_last   = m.owner;
        end
      end else if (req_1 || req_2) begin
        m.owner  = (req_1 && req_2) ? ((m_last == 1) ? 2 : 1) : (req_1 ? 1 : 2);
        m.wr     = (m.owner == 1) ? wr_1 : wr_2;
        m.addr   = (m.owner == 1) ? addr_1 : addr_2;
        m.data   = (m.owner == 1) ? wdata_1 : wdata_2;
        m.t0     = cyc;
        m.dirty  = 1'b0;
        m.active = 1'b1;
      end
      cyc++;
    end
  end

  // ---------------- per-cycle compare ----------------
  int          k, dk;
  logic        eg1, eg2, ed1, ed2, es1, es2, erd, ewr;
  logic [31:0] ewd, erdata, oth;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("rst_ctrl", {24'h0, gnt_1, gnt_2, done_1, done_2,
                           snoop_req_1, snoop_req_2, mem_rd, mem_wr}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_addrs", {22'h0, mem_addr, snoop_addr}, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
      end else begin
        {eg1, eg2, ed1, ed2, es1, es2, erd, ewr} = '0;
        ewd = '0;
        erdata = '0;
        if (m.active) begin
          k   = cyc - m.t0;
          dk  = done_k(m.wr);
          oth = (m.owner == 1) ? sdata_cfg_2 : sdata_cfg_1;
          eg1 = (m.owner == 1);
          eg2 = (m.owner == 2);
          ed1 = eg1 && (k == dk);
          ed2 = eg2 && (k == dk);
          if (m.wr) begin
            ewr = (k >= 1 && k <= L);
            ewd = m.data;
          end else if (k == 1) begin
            es1 = (m.owner == 2);
            es2 = (m.owner == 1);
          end else if (k >= 2 && k <= L + 1) begin
            if (m.dirty) begin
              ewr = 1'b1;
              ewd = oth;
            end else begin
              erd = 1'b1;
            end
          end
          erdata = m.wr ? m.data : (m.dirty ? oth : mem_word(m.addr));
        end
        check("gnt_1", gnt_1, eg1);
        check("gnt_2", gnt_2, eg2);
        check("done_1", done_1, ed1);
        check("done_2", done_2, ed2);
        check("snoop_req_1", snoop_req_1, es1);
        check("snoop_req_2", snoop_req_2, es2);
        check("mem_rd", mem_rd, erd);
        check("mem_wr", mem_wr, ewr);
        if (erd || ewr)   check("mem_addr", mem_addr, m.addr);
        if (ewr)          check("mem_wdata", mem_wdata, ewd);
        if (es1 || es2)   check("snoop_addr", snoop_addr, m.addr);
        if (ed1 || ed2)   check("rdata", rdata, erdata);
      end
    end
  end

  // ---------------- requester ----------------
  task automatic set_req(input int core, input logic r);
    if (core == 1) req_1 = r; else req_2 = r;
  endtask

  task automatic do_req(input int core, input logic w, input logic [4:0] a,
                        input logic [31:0] d, input int drop_at,
                        output int lat, output logic [31:0] rd);
    int waited;
    bit got;
    waited = 0;
    got = 1'b0;
    rd = '0;
    if (core == 1) begin wr_1 = w; addr_1 = a; wdata_1 = d; end
    else begin wr_2 = w; addr_2 = a; wdata_2 = d; end
    set_req(core, 1'b1);
    while (!got && waited < 40) begin
      @(posedge clk); #2;
      waited++;
      if (waited == drop_at) set_req(core, 1'b0);
      if ((core == 1 && done_1) || (core == 2 && done_2)) begin
        got = 1'b1;
        rd  = rdata;
      end
    end
    set_req(core, 1'b0);
    if (!got) check("req_timeout", 32'd0, 32'd1);
    lat = waited;
    // Request stays low through the cycle after done.
    repeat (2) begin @(posedge clk); #2; end
  endtask

  int          lat, lat2, s_wr, s_rd, s_s1, s_s2, s_g, waited;
  logic [31:0] rd, rd2;
  bit          got;

  initial begin
    reset = 1'b0;
    {req_1, req_2, wr_1, wr_2} = '0;
    addr_1 = '0; addr_2 = '0; wdata_1 = '0; wdata_2 = '0;
    b_req_1 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_state", {24'h0, gnt_1, gnt_2, done_1, done_2, mem_rd, mem_wr,
                          b_gnt_1, b_mem_rd}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #2;

    // Write from core 1.
    s_wr = n_mem_wr; s_s1 = n_snp1; s_s2 = n_snp2;
    do_req(1, 1'b1, 5'h0A, 32'hDEADBEEF, 0, lat, rd);
    check("wr_latency", lat, 5);
    check("wr_memwr_cycles", n_mem_wr - s_wr, 4);
    check("wr_no_snoop", (n_snp1 - s_s1) + (n_snp2 - s_s2), 0);
    check("wr_rdata", rd, 32'hDEADBEEF);

    // Clean read from core 2.
    s_rd = n_mem_rd; s_s1 = n_snp1;
    do_req(2, 1'b0, 5'h03, 32'h0, 0, lat, rd);
    check("clean_latency", lat, 6);
    check("clean_memrd_cycles", n_mem_rd - s_rd, 4);
    check("clean_snoop1_cycles", n_snp1 - s_s1, 1);
    check("clean_rdata", rd, 32'h12345678);

    // Dirty read from core 1; core 2 holds the line modified.
    dirty_cfg_2 = 1'b1;
    sdata_cfg_2 = 32'hCAFEF00D;
    s_rd = n_mem_rd; s_wr = n_mem_wr;
    do_req(1, 1'b0, 5'h07, 32'h0, 0, lat, rd);
    check("dirty_latency", lat, 6);
    check("dirty_memrd_cycles", n_mem_rd - s_rd, 0);
    check("dirty_memwr_cycles", n_mem_wr - s_wr, 4);
    check("dirty_rdata", rd, 32'hCAFEF00D);
    dirty_cfg_2 = 1'b0;

    // Request dropped early still completes.
    do_req(2, 1'b1, 5'h1F, 32'h0BADF00D, 2, lat, rd);
    check("early_drop_latency", lat, 5);
    check("early_drop_rdata", rd, 32'h0BADF00D);

    // Tie and round-robin: both cores issue two writes each.
    s_g = glog.size();
    fork
      begin
        do_req(1, 1'b1, 5'h11, 32'h11111111, 0, lat, rd);
        do_req(1, 1'b1, 5'h12, 32'h11112222, 0, lat, rd);
      end
      begin
        do_req(2, 1'b1, 5'h21 & 5'h1F, 32'h22221111, 0, lat2, rd2);
        do_req(2, 1'b1, 5'h02, 32'h22222222, 0, lat2, rd2);
      end
    join
    check("rr_grant_count", glog.size() - s_g, 4);
    if (glog.size() - s_g >= 4) begin
      check("rr_grant_0", glog[s_g],     1);
      check("rr_grant_1", glog[s_g + 1], 2);
      check("rr_grant_2", glog[s_g + 2], 1);
      check("rr_grant_3", glog[s_g + 3], 2);
    end

    // Reset during the MEM phase of a read, then restart.
    wr_1 = 1'b0; addr_1 = 5'h03; req_1 = 1'b1;
    repeat (3) begin @(posedge clk); #2; end
    check("pre_reset_memrd", mem_rd, 1);
    reset = 1'b0;
    #1;
    check("abort_outputs", {24'h0, gnt_1, gnt_2, done_1, done_2,
                            snoop_req_1, snoop_req_2, mem_rd, mem_wr}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;
    waited = 0; got = 1'b0;
    while (!got && waited < 40) begin
      @(posedge clk); #2;
      waited++;
      if (done_1) begin got = 1'b1; rd = rdata; end
    end
    req_1 = 1'b0;
    check("restart_done_seen", got, 1);
    check("restart_latency", waited, 6);
    check("restart_rdata", rd, 32'h12345678);
    repeat (2) begin @(posedge clk); #2; end

    // MEM_LAT=1 instance: single-cycle memory read.
    s_rd = b_n_mem_rd;
    b_req_1 = 1'b1;
    waited = 0; got = 1'b0;
    while (!got && waited < 20) begin
      @(posedge clk); #2;
      waited++;
      if (b_done_1) begin got = 1'b1; rd = b_rdata; end
    end
    b_req_1 = 1'b0;
    check("lat1_done_seen", got, 1);
    check("lat1_latency", waited, 3);
    check("lat1_memrd_cycles", b_n_mem_rd - s_rd, 1);
    check("lat1_rdata", rd, 32'h12345678);
    repeat (3) begin @(posedge clk); #2; end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
